// File: rtl/tick_gen_pkg.sv
// -----------------------------------------------------------------------------
// tick_gen_pkg
// Shared definitions for the programmable tick generator.
//   state_t        : controller state encoding (IDLE / RUN / PAUSE)
//   MODE_PERIODIC  : free-running tick every div_cur RUN cycles
//   MODE_ONESHOT   : single tick after a start pulse, then back to IDLE
// -----------------------------------------------------------------------------
package tick_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tick_gen_shadow.sv
// -----------------------------------------------------------------------------
// tick_gen_shadow
// Divisor shadow register with a valid/ready load port. A new divisor is
// captured into the shadow and only moved into div_cur at a safe point:
// immediately while the generator is idle, or on a tick while running, so a
// period is never cut short or stretched by a reload.
//
// Ports:
//   clki       in   clock, posedge
//   rst        in   synchronous active-high reset (drops any pending value)
//   clr        in   synchronous clear; freezes the shadow for this cycle
//   idle       in   generator is in IDLE
//   tick       in   generator tick this cycle
//   div_in     in   W  new divisor
//   div_valid  in   div_in is valid
//   div_ready  out  shadow empty, a transfer is accepted this cycle
//   div_cur    out  W  active divisor
// -----------------------------------------------------------------------------
module tick_gen_shadow #(
    parameter int          W           = 31,
    parameter int unsigned DEFAULT_DIV = 50000000
) (
    input  logic         clki,
    input  logic         rst,
    input  logic         clr,
    input  logic         idle,
    input  logic         tick,
    input  logic [W-1:0] div_in,
    input  logic         div_valid,
    output logic         div_ready,
    output logic [W-1:0] div_cur
);

    logic [W-1:0] shadow;
    logic         full;
    logic         apply;
    logic         capture;

    // A full shadow blocks new transfers, so apply and capture never coincide.
    assign apply     = full && (idle || tick) && !clr;
    assign capture   = div_valid && !full && !clr;
    assign div_ready = !full;

    // A divisor of zero would never tick; it is stored as one instead.
    always_ff @(posedge clki) begin
        if (rst) begin
            shadow  <= '0;
            full    <= 1'b0;
            div_cur <= W'(DEFAULT_DIV);
        end else if (apply) begin
            div_cur <= shadow;
            full    <= 1'b0;
        end else if (capture) begin
            shadow  <= (div_in == '0) ? W'(1) : div_in;
            full    <= 1'b1;
        end
    end

endmodule

// File: rtl/tick_gen_prog.sv
// -----------------------------------------------------------------------------
// tick_gen_prog
// Programmable tick/enable generator. Emits a one-cycle tick every div_cur
// cycles spent in RUN, in periodic or one-shot mode, with pause/resume,
// clear, a runtime-reloadable divisor and a wrapping tick counter.
//
// Optional feature macro: TICK_GEN_SQUARE_EN
//   defined   : sq_out toggles on every tick (period 2*div_cur while running)
//   undefined : sq_out is tied to 0
//
// Ports:
//   clki       in   clock, posedge
//   rst        in   synchronous active-high reset
//   en         in   run enable; low pauses with phase preserved
//   clr        in   synchronous clear of state and period counter
//   mode       in   0 periodic, 1 one-shot; latched on IDLE->RUN
//   start      in   one-shot trigger
//   div_in     in   W  new divisor
//   div_valid  in   div_in valid
//   div_ready  out  shadow register can accept div_in
//   tick       out  one-cycle enable pulse
//   busy       out  generator not idle
//   tick_cnt   out  CNT_W  ticks issued, wraps
//   div_cur    out  W  active divisor
//   sq_out     out  square wave
// -----------------------------------------------------------------------------
module tick_gen_prog
    import tick_gen_pkg::*;
#(
    parameter int          W           = 31,
    parameter int unsigned DEFAULT_DIV = 50000000,
    parameter int          CNT_W       = 8
) (
    input  logic             clki,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             mode,
    input  logic             start,
    input  logic [W-1:0]     div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] tick_cnt,
    output logic [W-1:0]     div_cur,
    output logic             sq_out
);

    state_t       state;
    logic [W-1:0] r_cnt;
    logic         mode_q;

    assign tick = (state == ST_RUN) && (r_cnt == div_cur - W'(1));
    assign busy = (state != ST_IDLE);

    tick_gen_shadow #(
        .W           (W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_shadow (
        .clki      (clki),
        .rst       (rst),
        .clr       (clr),
        .idle      (state == ST_IDLE),
        .tick      (tick),
        .div_in    (div_in),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .div_cur   (div_cur)
    );

    // Every cycle spent in RUN advances the phase, including the cycle in
    // which en drops; the phase is frozen only while in PAUSE. This makes a
    // pause of N cycles delay the next tick by exactly N cycles.
    always_ff @(posedge clki) begin
        if (rst) begin
            state  <= ST_IDLE;
            r_cnt  <= '0;
            mode_q <= MODE_PERIODIC;
        end else if (clr) begin
            state  <= ST_IDLE;
            r_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en && (mode == MODE_PERIODIC || start)) begin
                        state  <= ST_RUN;
                        r_cnt  <= '0;
                        mode_q <= mode;
                    end
                end
                ST_RUN: begin
                    if (tick && mode_q == MODE_ONESHOT) begin
                        state <= ST_IDLE;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= tick ? '0 : r_cnt + W'(1);
                        if (!en) begin
                            state <= ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (en) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // The tick counter survives clr; only rst zeroes it.
    always_ff @(posedge clki) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

`ifdef TICK_GEN_SQUARE_EN
    logic sq_q;

    always_ff @(posedge clki) begin
        if (rst) begin
            sq_q <= 1'b0;
        end else if (tick) begin
            sq_q <= !sq_q;
        end
    end

    assign sq_out = sq_q;
`else
    assign sq_out = 1'b0;
`endif

endmodule

// File: tb/tb_tick_gen_prog.sv
// -----------------------------------------------------------------------------
// tb_tick_gen_prog
// Directed bench for tick_gen_prog (DEFAULT_DIV=5, CNT_W=8). A behavioural
// model tracks the expected outputs cycle by cycle; directed literal checks
// pin the model at hand-computed points.
// -----------------------------------------------------------------------------
module tb_tick_gen_prog;

    localparam int W           = 31;
    localparam int DEFAULT_DIV = 5;
    localparam int CNT_W       = 8;

    logic             clki;
    logic             rst;
    logic             en;
    logic             clr;
    logic             mode;
    logic             start;
    logic [W-1:0]     div_in;
    logic             div_valid;
    logic             div_ready;
    logic             tick;
    logic             busy;
    logic [CNT_W-1:0] tick_cnt;
    logic [W-1:0]     div_cur;
    logic             sq_out;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 0;

    tick_gen_prog #(
        .W           (W),
        .DEFAULT_DIV (DEFAULT_DIV),
        .CNT_W       (CNT_W)
    ) dut (
        .clki      (clki),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .mode      (mode),
        .start     (start),
        .div_in    (div_in),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .tick      (tick),
        .busy      (busy),
        .tick_cnt  (tick_cnt),
        .div_cur   (div_cur),
        .sq_out    (sq_out)
    );

    initial begin
        clki = 1'b0;
        forever #5 clki = ~clki;
    end

    // Behavioural model: running/paused flags, the number of RUN cycles
    // completed in the current period, the active divisor and an optional
    // pending divisor.
    bit     m_active;
    bit     m_held;
    bit     m_single;
    longint m_phase;
    longint m_div;
    bit     m_pend;
    longint m_pend_val;
    int     m_ticks;
    bit     m_sq;

    function automatic bit exp_tick();
        return m_active && !m_held && (m_phase == m_div - 1);
    endfunction

    function automatic bit exp_sq();
`ifdef TICK_GEN_SQUARE_EN
        return m_sq;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clki) begin : model
        bit t_now;
        t_now = exp_tick();
        if (rst) begin
            m_active = 0; m_held = 0; m_single = 0; m_phase = 0;
            m_div = DEFAULT_DIV; m_pend = 0; m_pend_val = 0;
            m_ticks = 0; m_sq = 0;
        end else begin
            if (t_now) begin
                m_ticks = m_ticks + 1;
                m_sq    = !m_sq;
            end
            if (clr) begin
                m_active = 0; m_held = 0; m_phase = 0;
            end else begin
                if (m_pend && (!m_active || t_now)) begin
                    m_div  = m_pend_val;
                    m_pend = 0;
                end else if (div_valid && !m_pend) begin
                    m_pend     = 1;
                    m_pend_val = (div_in == 0) ? 1 : longint'(div_in);
                end
                if (!m_active) begin
                    if (en && (!mode || start)) begin
                        m_active = 1; m_held = 0; m_phase = 0; m_single = mode;
                    end
                end else if (!m_held) begin
                    if (t_now && m_single) begin
                        m_active = 0; m_phase = 0;
                    end else begin
                        m_phase = t_now ? 0 : m_phase + 1;
                        if (!en) m_held = 1;
                    end
                end else if (en) begin
                    m_held = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(negedge clki) begin
        if (check_en) begin
            checkOutput("cmp_tick",      longint'(tick),      longint'(exp_tick()));
            checkOutput("cmp_busy",      longint'(busy),      longint'(m_active));
            checkOutput("cmp_div_ready", longint'(div_ready), longint'(!m_pend));
            checkOutput("cmp_tick_cnt",  longint'(tick_cnt),  longint'(m_ticks % 256));
            checkOutput("cmp_div_cur",   longint'(div_cur),   m_div);
            checkOutput("cmp_sq_out",    longint'(sq_out),    longint'(exp_sq()));
        end
    end

    task automatic applyStimulus(input bit r, input bit c, input bit e, input bit m,
                                 input bit s, input bit dv, input int unsigned d);
        rst = r; clr = c; en = e; mode = m; start = s; div_valid = dv;
        div_in = W'(d);
    endtask

    task automatic next_cycle();
        @(negedge clki);
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        next_cycle();
        check_en = 1;
        $display("[TB] reset values");
        checkOutput("rst_tick",      longint'(tick),      0);
        checkOutput("rst_busy",      longint'(busy),      0);
        checkOutput("rst_div_ready", longint'(div_ready), 1);
        checkOutput("rst_tick_cnt",  longint'(tick_cnt),  0);
        checkOutput("rst_div_cur",   longint'(div_cur),   5);
        checkOutput("rst_sq_out",    longint'(sq_out),    0);

        $display("[TB] periodic, divisor 5");
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 15; k++) begin
            next_cycle();
            checkOutput("p_tick", longint'(tick), (k % 5 == 0) ? 1 : 0);
            checkOutput("p_busy", longint'(busy), 1);
        end
        next_cycle();
        checkOutput("p_tick_cnt", longint'(tick_cnt), 3);

        $display("[TB] pause for 4 cycles at phase 2");
        next_cycle();
        next_cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        checkOutput("pause_no_tick", longint'(tick), 0);
        checkOutput("pause_busy",    longint'(busy), 1);
        next_cycle();
`ifdef TICK_GEN_SQUARE_EN
        checkOutput("pause_sq_hold", longint'(sq_out), 1);
`else
        checkOutput("pause_sq_zero", longint'(sq_out), 0);
`endif
        next_cycle();
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        next_cycle();
        checkOutput("resume_no_tick", longint'(tick), 0);
        next_cycle();
        checkOutput("resume_tick", longint'(tick), 1);
        next_cycle();
        checkOutput("resume_tick_cnt", longint'(tick_cnt), 4);

        $display("[TB] reload divisor 3 while running");
        next_cycle();
        applyStimulus(0, 0, 1, 0, 0, 1, 3);
        next_cycle();
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("rl_ready_low", longint'(div_ready), 0);
        next_cycle();
        next_cycle();
        checkOutput("rl_old_tick",      longint'(tick),      1);
        checkOutput("rl_old_div",       longint'(div_cur),   5);
        checkOutput("rl_ready_low_tk",  longint'(div_ready), 0);
        next_cycle();
        checkOutput("rl_ready_back",    longint'(div_ready), 1);
        checkOutput("rl_new_div",       longint'(div_cur),   3);
        checkOutput("rl_tick_cnt",      longint'(tick_cnt),  5);
        next_cycle();
        next_cycle();
        checkOutput("rl_tick_3a", longint'(tick), 1);
        next_cycle();
        next_cycle();
        next_cycle();
        checkOutput("rl_tick_3b", longint'(tick), 1);

        $display("[TB] clear, reload 5 in idle, one-shot");
        next_cycle();
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        next_cycle();
        checkOutput("clr_busy",     longint'(busy),     0);
        checkOutput("clr_tick_cnt", longint'(tick_cnt), 7);
        checkOutput("clr_div_kept", longint'(div_cur),  3);
        applyStimulus(0, 0, 0, 1, 0, 1, 5);
        next_cycle();
        checkOutput("idle_ready_low", longint'(div_ready), 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        next_cycle();
        checkOutput("idle_apply_div", longint'(div_cur),   5);
        checkOutput("idle_ready",     longint'(div_ready), 1);
        applyStimulus(0, 0, 1, 1, 1, 0, 0);
        next_cycle();
        checkOutput("os_busy", longint'(busy), 1);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        next_cycle();
        next_cycle();
        applyStimulus(0, 0, 1, 0, 1, 0, 0);
        next_cycle();
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        next_cycle();
        checkOutput("os_tick", longint'(tick), 1);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            checkOutput("os_done_tick", longint'(tick), 0);
            checkOutput("os_done_busy", longint'(busy), 0);
        end
        checkOutput("os_tick_cnt", longint'(tick_cnt), 8);

        $display("[TB] divisor 0 clamps to 1, counter wrap");
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        checkOutput("zero_div_cur", longint'(div_cur), 1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 257; k++) begin
            next_cycle();
            if (k == 1)   checkOutput("d1_first_tick", longint'(tick), 1);
            if (k == 256) checkOutput("d1_cnt_255",    longint'(tick_cnt), 255);
            if (k == 257) checkOutput("d1_cnt_wrap",   longint'(tick_cnt), 0);
        end

        $display("[TB] reset with pending shadow");
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        next_cycle();
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 6; k++) next_cycle();
        checkOutput("rp_tick_cnt", longint'(tick_cnt), 1);
        applyStimulus(0, 0, 1, 0, 0, 1, 7);
        next_cycle();
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("rp_pending", longint'(div_ready), 0);
        next_cycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        next_cycle();
        checkOutput("rp_busy",      longint'(busy),      0);
        checkOutput("rp_div_cur",   longint'(div_cur),   5);
        checkOutput("rp_ready",     longint'(div_ready), 1);
        checkOutput("rp_tick_cnt0", longint'(tick_cnt),  0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            checkOutput("rp_restart_tick", longint'(tick), (k == 5) ? 1 : 0);
        end
        checkOutput("rp_restart_div", longint'(div_cur), 5);

        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        check_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tick_gen_prog.md
Name: tick_gen_prog

Overview:
Programmable tick/enable generator; the parametrised successor of the fixed-modulus one-cycle enable divider.
- Emits a one-cycle `tick` every `div_cur` clock cycles.
- Divisor is reloadable at runtime through a valid/ready shadow register, applied glitch-free at the period boundary.
- Adds periodic and one-shot modes, pause/resume, clear, and a tick counter.
- Drives the 0-9/9-0 counters and display scan logic from the single board clock.

Parameters:
W, 31, divisor and period-counter width
DEFAULT_DIV, 50000000, divisor after reset (must be >= 1 and < 2^W)
CNT_W, 8, width of the wrapping tick counter

Ports:
clki  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
en  in  1  run enable; low pauses the counter, phase preserved
clr  in  1  synchronous clear of state and period counter
mode  in  1  0 = periodic, 1 = one-shot; sampled on IDLE->RUN
start  in  1  one-shot trigger pulse
div_in  in  W  new divisor value
div_valid  in  1  div_in valid
div_ready  out  1  shadow register empty, can accept div_in
tick  out  1  one-cycle enable pulse
busy  out  1  state != IDLE
tick_cnt  out  CNT_W  number of ticks issued, wraps
div_cur  out  W  active divisor
sq_out  out  1  square wave (optional feature)

Behaviour:
- Reset values: state=IDLE, r_cnt=0, div_cur=DEFAULT_DIV, shadow empty, div_ready=1, tick=0, busy=0, tick_cnt=0, sq_out=0, mode_q=0.
- Precedence: rst overrides clr; clr overrides all other inputs.
- States: IDLE, RUN, PAUSE.
- IDLE->RUN:
  - mode=0: when en=1.
  - mode=1: when en=1 and start=1.
  - mode_q latched on this transition; mode changes during RUN/PAUSE are ignored.
- RUN->PAUSE when en=0; r_cnt holds.
- PAUSE->RUN when en=1.
- r_cnt is reset to 0 on entry to RUN from IDLE.
- tick: combinational, tick = (state==RUN) && (r_cnt==div_cur-1).
  - First tick falls on the div_cur-th cycle spent in RUN.
  - Periodic: r_cnt wraps to 0 on tick, giving a tick every div_cur RUN cycles.
  - One-shot: state returns to IDLE on the cycle after the tick and r_cnt=0; start while RUN/PAUSE is ignored.
- clr: state=IDLE, r_cnt=0. div_cur, shadow, tick_cnt and sq_out are kept.
- Divisor handshake:
  - Transfer occurs when div_valid && div_ready. The value goes to the shadow register and div_ready=0 from the next cycle.
  - div_in=0 is stored as 1.
  - Shadow is applied to div_cur in IDLE on the cycle after capture, or in RUN on the tick cycle; the new period starts immediately after.
  - div_ready returns to 1 on the cycle after the apply. No transfer is possible on the apply cycle itself.
  - In PAUSE the shadow waits.
- div_cur=1: tick every RUN cycle.
- tick_cnt increments on every tick and wraps from 2^CNT_W-1 to 0.
- rst mid-operation: all state returns to reset values; a pending shadow is discarded.

Optional Feature:
TICK_GEN_SQUARE_EN
- Defined: sq_out toggles on every tick, giving a 50%-duty wave of period 2*div_cur while running. sq_out holds in PAUSE/IDLE and is 0 after rst.
- Undefined: sq_out tied to 0; no extra flops.

Decomposition:
- Package tick_gen_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2;
  - MODE_PERIODIC=1'b0, MODE_ONESHOT=1'b1.
- One natural sub-module, tick_gen_shadow: shadow register, div_ready flag, zero-clamp and apply strobe. The FSM, r_cnt, tick_cnt and sq_out stay in the top.

Test Plan:
- DEFAULT_DIV=5, mode=0, en=1 after rst -> tick on RUN cycles 5,10,15; tick_cnt=1,2,3; busy=1 throughout.
- Periodic running, div_in=3 handshaked at r_cnt=1 -> tick at r_cnt=4 with the old divisor, then every 3 cycles.
  - div_ready low from the cycle after the handshake until the cycle after that tick.
  - div_cur reads 3 after the tick.
- mode=1, start pulse -> single tick 5 cycles later, then IDLE, busy=0. A second start during RUN produces no extra tick.
- en low for 4 cycles at r_cnt=2 -> next tick delayed by exactly 4 cycles; sq_out (macro on) holds level during the pause.
- div_in=0 handshaked in IDLE, en=1, CNT_W=8 -> div_cur=1, tick every cycle; tick_cnt wraps 255->0 on the 256th tick.
- rst asserted mid-period with a pending shadow -> next cycle state=IDLE, div_cur=5, div_ready=1, tick_cnt=0. Restart gives the first tick after 5 cycles.
